aq_vpu_group_pipe_ctrl: RTL and testbench

//  VPU group-0 pipeline sequencer: issue side of the EU sel/stall protocol. Tracks one inst per

---
 rtl/aq_vpu_group_pipe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_aq_vpu_group_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aq_vpu_group_pipe_ctrl.sv
// aq_vpu_group_pipe_ctrl: VPU group-0 issue-side pipeline sequencer.
// Tracks one instruction per stage EX1..EX5, drives sel/eu_sel/stall to the
// execution units, captures early-result flags and retires strictly in order
// through a single writeback port.
// Optional build macro: VPU_PIPE_PERF_CNT_EN adds three 32-bit perf counters.
module aq_vpu_group_pipe_ctrl #(
  parameter int EU_NUM = 10
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              idu_vpu_issue_vld,
  input  logic [EU_NUM-1:0] idu_vpu_issue_eu_sel,
  output logic              vpu_idu_issue_rdy,
  input  logic              rtu_vpu_flush,
  output logic              vpu_group_0_xx_ex1_sel,
  output logic              vpu_group_0_xx_ex2_sel,
  output logic              vpu_group_0_xx_ex3_sel,
  output logic              vpu_group_0_xx_ex4_sel,
  output logic [EU_NUM-1:0] vpu_group_0_xx_ex1_eu_sel,
  output logic [EU_NUM-1:0] vpu_group_0_xx_ex2_eu_sel,
  output logic [EU_NUM-1:0] vpu_group_0_xx_ex3_eu_sel,
  output logic [EU_NUM-1:0] vpu_group_0_xx_ex4_eu_sel,
  output logic              vpu_group_0_xx_ex2_stall,
  output logic              vpu_group_0_xx_ex3_stall,
  output logic              vpu_group_0_xx_ex4_stall,
  output logic              vpu_group_0_xx_ex5_stall,
  input  logic              eu_vpu_ex2_result_ready_in_ex3,
  input  logic              eu_vpu_ex3_result_ready_in_ex4,
  output logic              vpu_wb_vld,
  output logic [2:0]        vpu_wb_stage,
  output logic [EU_NUM-1:0] vpu_wb_eu_sel,
  input  logic              wb_vpu_rdy
`ifdef VPU_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_early_ex3_cnt,
  output logic [31:0]       perf_early_ex4_cnt
`endif
);

  logic [5:1]        r_vld;
  logic [EU_NUM-1:0] r_eu_sel [1:5];
  logic              r_ex3_done;
  logic              r_ex4_done;

  // Only the oldest (highest valid) stage may present a result.
  logic w_wb_from5, w_wb_from4, w_wb_from3;
  logic w_wb_vld, w_wb_fire;
  logic w_fire5, w_fire4, w_fire3;
  logic w_stall5, w_stall4, w_stall3, w_stall2, w_hold1;
  logic w_issue_rdy, w_issue;
  logic w_mv1, w_mv2, w_mv3, w_mv4;

  assign w_wb_from5 = r_vld[5];
  assign w_wb_from4 = !r_vld[5] && r_vld[4] && r_ex4_done;
  assign w_wb_from3 = !r_vld[5] && !r_vld[4] && r_vld[3] && r_ex3_done;
  assign w_wb_vld   = !rtu_vpu_flush && (w_wb_from5 || w_wb_from4 || w_wb_from3);
  assign w_wb_fire  = w_wb_vld && wb_vpu_rdy;
  assign w_fire5    = w_wb_fire && w_wb_from5;
  assign w_fire4    = w_wb_fire && w_wb_from4;
  assign w_fire3    = w_wb_fire && w_wb_from3;

  // A stage stalls only when it is occupied, not retiring, and the next one stalls.
  assign w_stall5 = r_vld[5] && !w_wb_fire;
  assign w_stall4 = r_vld[4] && !w_fire4 && w_stall5;
  assign w_stall3 = r_vld[3] && !w_fire3 && w_stall4;
  assign w_stall2 = r_vld[2] && w_stall3;
  assign w_hold1  = r_vld[1] && w_stall2;

  assign w_issue_rdy = !w_hold1 && !rtu_vpu_flush;
  assign w_issue     = idu_vpu_issue_vld && w_issue_rdy;

  assign w_mv1 = r_vld[1] && !w_stall2;
  assign w_mv2 = r_vld[2] && !w_stall3;
  assign w_mv3 = r_vld[3] && !w_fire3 && !w_stall4;
  assign w_mv4 = r_vld[4] && !w_fire4 && !w_stall5;

  // Pipeline state: shift, retire, or hold per stage; flush wipes everything.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_vld      <= '0;
      r_ex3_done <= 1'b0;
      r_ex4_done <= 1'b0;
      for (int i = 1; i <= 5; i++) r_eu_sel[i] <= '0;
    end else if (rtu_vpu_flush) begin
      r_vld      <= '0;
      r_ex3_done <= 1'b0;
      r_ex4_done <= 1'b0;
      for (int i = 1; i <= 5; i++) r_eu_sel[i] <= '0;
    end else begin
      if (w_issue) begin
        r_vld[1]    <= 1'b1;
        r_eu_sel[1] <= idu_vpu_issue_eu_sel;
      end else if (w_mv1) begin
        r_vld[1]    <= 1'b0;
        r_eu_sel[1] <= '0;
      end

      if (w_mv1) begin
        r_vld[2]    <= 1'b1;
        r_eu_sel[2] <= r_eu_sel[1];
      end else if (w_mv2) begin
        r_vld[2]    <= 1'b0;
        r_eu_sel[2] <= '0;
      end

      if (w_mv2) begin
        r_vld[3]    <= 1'b1;
        r_eu_sel[3] <= r_eu_sel[2];
        r_ex3_done  <= eu_vpu_ex2_result_ready_in_ex3;
      end else if (w_mv3 || w_fire3) begin
        r_vld[3]    <= 1'b0;
        r_eu_sel[3] <= '0;
        r_ex3_done  <= 1'b0;
      end

      if (w_mv3) begin
        r_vld[4]    <= 1'b1;
        r_eu_sel[4] <= r_eu_sel[3];
        r_ex4_done  <= r_ex3_done || eu_vpu_ex3_result_ready_in_ex4;
      end else if (w_mv4 || w_fire4) begin
        r_vld[4]    <= 1'b0;
        r_eu_sel[4] <= '0;
        r_ex4_done  <= 1'b0;
      end

      if (w_mv4) begin
        r_vld[5]    <= 1'b1;
        r_eu_sel[5] <= r_eu_sel[4];
      end else if (w_fire5) begin
        r_vld[5]    <= 1'b0;
        r_eu_sel[5] <= '0;
      end
    end
  end

  // Writeback source select; outputs read zero when nothing is retiring.
  always_comb begin
    vpu_wb_stage  = 3'b000;
    vpu_wb_eu_sel = '0;
    if (w_wb_vld) begin
      vpu_wb_stage = {w_wb_from5, w_wb_from4, w_wb_from3};
      if (w_wb_from5)      vpu_wb_eu_sel = r_eu_sel[5];
      else if (w_wb_from4) vpu_wb_eu_sel = r_eu_sel[4];
      else                 vpu_wb_eu_sel = r_eu_sel[3];
    end
  end

  assign vpu_wb_vld                = w_wb_vld;
  assign vpu_idu_issue_rdy         = w_issue_rdy;
  assign vpu_group_0_xx_ex1_sel    = r_vld[1];
  assign vpu_group_0_xx_ex2_sel    = r_vld[2];
  assign vpu_group_0_xx_ex3_sel    = r_vld[3];
  assign vpu_group_0_xx_ex4_sel    = r_vld[4];
  assign vpu_group_0_xx_ex1_eu_sel = r_eu_sel[1];
  assign vpu_group_0_xx_ex2_eu_sel = r_eu_sel[2];
  assign vpu_group_0_xx_ex3_eu_sel = r_eu_sel[3];
  assign vpu_group_0_xx_ex4_eu_sel = r_eu_sel[4];
  assign vpu_group_0_xx_ex2_stall  = w_stall2;
  assign vpu_group_0_xx_ex3_stall  = w_stall3;
  assign vpu_group_0_xx_ex4_stall  = w_stall4;
  assign vpu_group_0_xx_ex5_stall  = w_stall5;

`ifdef VPU_PIPE_PERF_CNT_EN
  // Free-running perf counters; wrap naturally at 2^32.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      perf_stall_cnt     <= '0;
      perf_early_ex3_cnt <= '0;
      perf_early_ex4_cnt <= '0;
    end else begin
      if (w_hold1) perf_stall_cnt     <= perf_stall_cnt + 32'd1;
      if (w_fire3) perf_early_ex3_cnt <= perf_early_ex3_cnt + 32'd1;
      if (w_fire4) perf_early_ex4_cnt <= perf_early_ex4_cnt + 32'd1;
    end
  end
`endif

  // A non-one-hot target is still accepted unchanged; flag it here only.
  a_issue_onehot: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    w_issue |-> $onehot(idu_vpu_issue_eu_sel));

endmodule

// File: tb/tb_aq_vpu_group_pipe_ctrl.sv
// Directed bench for aq_vpu_group_pipe_ctrl with hand-computed expectations.
module tb_aq_vpu_group_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_vld = 1'b0;
  logic [9:0] issue_eu = '0;
  logic       issue_rdy;
  logic       flush = 1'b0;
  logic       ex1_sel, ex2_sel, ex3_sel, ex4_sel;
  logic [9:0] ex1_eu, ex2_eu, ex3_eu, ex4_eu;
  logic       ex2_stall, ex3_stall, ex4_stall, ex5_stall;
  logic       rdy3 = 1'b0;
  logic       rdy4 = 1'b0;
  logic       wb_vld;
  logic [2:0] wb_stage;
  logic [9:0] wb_eu;
  logic       wb_rdy = 1'b0;
`ifdef VPU_PIPE_PERF_CNT_EN
  logic [31:0] perf_stall, perf_e3, perf_e4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aq_vpu_group_pipe_ctrl #(.EU_NUM(10)) dut (
    .forever_cpuclk                 (clk),
    .cpurst                         (rst),
    .idu_vpu_issue_vld              (issue_vld),
    .idu_vpu_issue_eu_sel           (issue_eu),
    .vpu_idu_issue_rdy              (issue_rdy),
    .rtu_vpu_flush                  (flush),
    .vpu_group_0_xx_ex1_sel         (ex1_sel),
    .vpu_group_0_xx_ex2_sel         (ex2_sel),
    .vpu_group_0_xx_ex3_sel         (ex3_sel),
    .vpu_group_0_xx_ex4_sel         (ex4_sel),
    .vpu_group_0_xx_ex1_eu_sel      (ex1_eu),
    .vpu_group_0_xx_ex2_eu_sel      (ex2_eu),
    .vpu_group_0_xx_ex3_eu_sel      (ex3_eu),
    .vpu_group_0_xx_ex4_eu_sel      (ex4_eu),
    .vpu_group_0_xx_ex2_stall       (ex2_stall),
    .vpu_group_0_xx_ex3_stall       (ex3_stall),
    .vpu_group_0_xx_ex4_stall       (ex4_stall),
    .vpu_group_0_xx_ex5_stall       (ex5_stall),
    .eu_vpu_ex2_result_ready_in_ex3 (rdy3),
    .eu_vpu_ex3_result_ready_in_ex4 (rdy4),
    .vpu_wb_vld                     (wb_vld),
    .vpu_wb_stage                   (wb_stage),
    .vpu_wb_eu_sel                  (wb_eu),
    .wb_vpu_rdy                     (wb_rdy)
`ifdef VPU_PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt                 (perf_stall),
    .perf_early_ex3_cnt             (perf_e3),
    .perf_early_ex4_cnt             (perf_e4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stalls();
    return 32'({ex5_stall, ex4_stall, ex3_stall, ex2_stall});
  endfunction

  function automatic logic [31:0] sels();
    return 32'({ex4_sel, ex3_sel, ex2_sel, ex1_sel});
  endfunction

  // One instruction through an empty pipe; ready flags held for the whole run.
  task automatic run_single(input string nm, input logic r3, input logic r4,
                            input int exp_c, input logic [2:0] exp_stage);
    issue_vld = 1'b1; issue_eu = 10'h001; rdy3 = r3; rdy4 = r4; wb_rdy = 1'b1;
    #1 chk({nm, "_issue_rdy"}, 32'(issue_rdy), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      step();
      issue_vld = 1'b0;
      #1;
      chk($sformatf("%s_wbvld_c%0d", nm, c), 32'(wb_vld), 32'(c == exp_c));
      chk($sformatf("%s_ex1sel_c%0d", nm, c), 32'(ex1_sel), 32'(c == 1));
      chk($sformatf("%s_ex2sel_c%0d", nm, c), 32'(ex2_sel), 32'(c == 2));
      if (c == exp_c) begin
        chk({nm, "_wbstage"}, 32'(wb_stage), 32'(exp_stage));
        chk({nm, "_wbeu"}, 32'(wb_eu), 32'h001);
      end
    end
    rdy3 = 1'b0; rdy4 = 1'b0;
  endtask

  initial begin
    logic [9:0] r3_m;
    logic [9:0] r4_m;
    logic [12:0] st_wbr;
    logic [12:0] st_iv;
    logic [12:0] st_rdy;
    logic [12:0] st_stall;
    logic [12:0] st_wbv;
    logic [9:0]  st_issue_eu [13];
    logic [9:0]  st_wb_eu [13];

    // Reset state
    #12;
    chk("rst_sel", sels(), 32'd0);
    chk("rst_stall", stalls(), 32'd0);
    chk("rst_wbvld", 32'(wb_vld), 32'd0);
    chk("rst_wbstage", 32'(wb_stage), 32'd0);
    chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Single-issue latencies
    run_single("ex3_early", 1'b1, 1'b0, 3, 3'b001);
    run_single("ex4_early", 1'b0, 1'b1, 4, 3'b010);
    run_single("ex5_late",  1'b0, 1'b0, 5, 3'b100);

    // Back-to-back: inst0 none, inst1 ex3-early, inst2 ex4-early, inst3 ex3-early
    r3_m = 10'b0000101000;
    r4_m = 10'b0000100000;
    step();
    for (int c = 0; c <= 9; c++) begin
      issue_vld = (c < 4);
      issue_eu  = 10'(1 << c);
      rdy3      = r3_m[c];
      rdy4      = r4_m[c];
      wb_rdy    = 1'b1;
      #1;
      if (c < 4) chk($sformatf("b2b_issue_rdy_c%0d", c), 32'(issue_rdy), 32'd1);
      chk($sformatf("b2b_wbvld_c%0d", c), 32'(wb_vld), 32'(c >= 5 && c <= 8));
      chk($sformatf("b2b_wbeu_c%0d", c), 32'(wb_eu),
          (c >= 5 && c <= 8) ? 32'(1 << (c - 5)) : 32'd0);
      chk($sformatf("b2b_wbstage_c%0d", c), 32'(wb_stage),
          (c >= 5 && c <= 8) ? 32'd4 : 32'd0);
      step();
    end
    issue_vld = 1'b0; rdy3 = 1'b0; rdy4 = 1'b0;

    // Writeback back-pressure with continuous issue, then drain
    st_wbr   = 13'b1111111000000;
    st_iv    = 13'b0000001111111;
    st_rdy   = 13'b1111111011111;
    st_stall = 13'b0000000100000;
    st_wbv   = 13'b0111111100000;
    st_issue_eu = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h020,
                    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    st_wb_eu    = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h001, 10'h001,
                    10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h000};
    for (int c = 0; c <= 12; c++) begin
      wb_rdy    = st_wbr[c];
      issue_vld = st_iv[c];
      issue_eu  = st_issue_eu[c];
      #1;
      chk($sformatf("stl_issue_rdy_c%0d", c), 32'(issue_rdy), 32'(st_rdy[c]));
      chk($sformatf("stl_stalls_c%0d", c), stalls(), st_stall[c] ? 32'hF : 32'h0);
      chk($sformatf("stl_wbvld_c%0d", c), 32'(wb_vld), 32'(st_wbv[c]));
      chk($sformatf("stl_wbeu_c%0d", c), 32'(wb_eu), 32'(st_wb_eu[c]));
      step();
    end
    issue_vld = 1'b0;

    // Flush with three instructions in flight; the oldest is ex3-early
    for (int c = 0; c <= 7; c++) begin
      issue_vld = (c <= 3);
      issue_eu  = 10'(1 << c);
      rdy3      = (c == 2);
      flush     = (c == 3);
      wb_rdy    = 1'b1;
      #1;
      if (c < 3) chk($sformatf("fl_issue_rdy_c%0d", c), 32'(issue_rdy), 32'd1);
      if (c == 3) begin
        chk("fl_sel_during", sels(), 32'h7);
        chk("fl_wbvld_during", 32'(wb_vld), 32'd0);
        chk("fl_issue_rdy_during", 32'(issue_rdy), 32'd0);
      end else if (c >= 4) begin
        chk($sformatf("fl_sel_c%0d", c), sels(), 32'd0);
        chk($sformatf("fl_stall_c%0d", c), stalls(), 32'd0);
        chk($sformatf("fl_wbvld_c%0d", c), 32'(wb_vld), 32'd0);
        chk($sformatf("fl_issue_rdy_c%0d", c), 32'(issue_rdy), 32'd1);
      end
      step();
    end
    flush = 1'b0; rdy3 = 1'b0;

    // Reset asserted in the middle of a full stall
    for (int c = 0; c <= 5; c++) begin
      wb_rdy    = 1'b0;
      issue_vld = 1'b1;
      issue_eu  = 10'(1 << c);
      #1;
      if (c == 5) begin
        chk("rs_pre_stall", stalls(), 32'hF);
        chk("rs_pre_issue_rdy", 32'(issue_rdy), 32'd0);
      end
      if (c < 5) step();
    end
    rst = 1'b1;
    #1;
    chk("rs_sel", sels(), 32'd0);
    chk("rs_eu", 32'({ex4_eu, ex3_eu} | {ex2_eu, ex1_eu}), 32'd0);
    chk("rs_stall", stalls(), 32'd0);
    chk("rs_wbvld", 32'(wb_vld), 32'd0);
    chk("rs_wbstage", 32'(wb_stage), 32'd0);
    issue_vld = 1'b0;
    wb_rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rs_post_issue_rdy_c%0d", c), 32'(issue_rdy), 32'd1);
      chk($sformatf("rs_post_wbvld_c%0d", c), 32'(wb_vld), 32'd0);
      chk($sformatf("rs_post_sel_c%0d", c), sels(), 32'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
